// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_e     : IDLE / RUN control state
//   mode_e      : output shape (SQUARE = ~50% duty, PULSE = one-cycle strobe)
//   clamp_div() : maps divide ratios 0 and 1 to 2 (smallest legal period)
//   CLK_DIV_W / CLK_DIV_DEF : default ratio width and reset ratio
package clk_div_pkg;

    localparam int unsigned CLK_DIV_W   = 8;
    localparam int unsigned CLK_DIV_DEF = 4;

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_e;
    typedef enum logic { SQUARE = 1'b0, PULSE = 1'b1 } mode_e;

    // Ratios below 2 cannot form a period with both a start and a boundary
    // cycle, so they are promoted to 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'd2) ? 32'd2 : n;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog.
//   en      : run enable (0 forces idle)
//   load    : one-cycle request to capture div_in
//   div_in  : requested divide ratio
//   mode    : 0 = square output, 1 = pulse output
//   clk_div : registered divided clock
//   tick    : registered strobe on the first cycle of each period
//   pend    : a loaded ratio is waiting for the next boundary
// master = the block driving controls, slave = the divider itself.
interface clk_div_prog_if #(
    parameter int unsigned DIV_W = 8
);
    logic             en;
    logic             load;
    logic [DIV_W-1:0] div_in;
    logic             mode;
    logic             clk_div;
    logic             tick;
    logic             pend;

    modport master (output en, load, div_in, mode, input clk_div, tick, pend);
    modport slave  (input en, load, div_in, mode, output clk_div, tick, pend);
endinterface

// File: rtl/clk_div_cnt.sv
// Modulo-N period counter.
//   clk, rst  : clock, synchronous active-high reset
//   run       : block is currently in RUN
//   en        : run enable for the next cycle
//   div       : active ratio N (always >= 2)
//   cnt_d     : counter value for the next cycle (lets the parent decode
//               registered outputs that line up with the counter)
//   boundary  : this cycle is the last of a period (RUN, cnt == N-1)
module clk_div_cnt #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] cnt_d,
    output logic             boundary
);
    logic [DIV_W-1:0] cnt_q;
    logic             wrap;

    always_comb begin
        // >= rather than == keeps the counter bounded even if it ever sat
        // above N-1; in normal operation both are equivalent.
        wrap     = (cnt_q >= div - {{(DIV_W-1){1'b0}}, 1'b1});
        boundary = run && wrap;
        // Leaving RUN, sitting in IDLE, entering RUN and wrapping all land
        // on 0; only a mid-period RUN cycle that stays enabled advances.
        cnt_d    = (run && en && !wrap) ? cnt_q + {{(DIV_W-1){1'b0}}, 1'b1}
                                        : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free ratio and mode updates.
//   clk, rst : clock, synchronous active-high reset
//   bus      : clk_div_prog_if slave (en/load/div_in/mode in,
//              clk_div/tick/pend out)
// New ratios and mode changes are held until a period boundary (or IDLE) so
// the output never shows a truncated or stretched partial period.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = CLK_DIV_W,
    parameter int unsigned DEF_DIV = CLK_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEF_DIV)));

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] cnt_d;
    logic             boundary;
    logic [DIV_W-1:0] half_n;
    logic             apply;

    clk_div_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q == RUN),
        .en       (bus.en),
        .div      (cur_div_q),
        .cnt_d    (cnt_d),
        .boundary (boundary)
    );

    always_comb begin
        state_d    = bus.en ? RUN : IDLE;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        mode_d     = mode_q;

        // Ratio and mode are only swapped where a new period starts.
        apply = boundary || (state_q == IDLE);
        if (apply) begin
            mode_d = mode_e'(bus.mode);
            if (pend_q) begin
                cur_div_d = pend_div_q;
                pend_d    = 1'b0;
            end
        end

        // A load on a boundary lands in pend_div after the old pending value
        // has already been consumed, so it waits for the following boundary.
        if (bus.load) begin
            pend_div_d = DIV_W'(clamp_div(32'(bus.div_in)));
            pend_d     = 1'b1;
        end

        // Decode against next-cycle counter/ratio/mode so the registered
        // outputs are aligned with the counter.
        half_n    = (cur_div_d >> 1) + {{(DIV_W-1){1'b0}}, cur_div_d[0]};
        tick_d    = (state_d == RUN) && (cnt_d == '0);
        clk_div_d = (state_d == RUN) &&
                    ((mode_d == PULSE) ? tick_d : (cnt_d < half_n));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= SQUARE;
            cur_div_q  <= RST_DIV;
            pend_div_q <= RST_DIV;
            pend_q     <= 1'b0;
            clk_div_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_div_q  <= clk_div_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk_div = clk_div_q;
    assign bus.tick    = tick_q;
    assign bus.pend    = pend_q;
endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    clk_div_prog_if #(.DIV_W(8)) bus ();

    clk_div_prog #(.DIV_W(8), .DEF_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    // Steps n cycles, checking clk_div/tick against bit strings (MSB first).
    task automatic run_seq(input string tag, input int n,
                           input logic [15:0] eclk, input logic [15:0] etick);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s clk_div[%0d]", tag, i), bus.clk_div, eclk[n-1-i]);
            chk($sformatf("%s tick[%0d]", tag, i), bus.tick, etick[n-1-i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.div_in = 8'd0; bus.mode = 1'b0;
        step(); step();
        chk("reset clk_div", bus.clk_div, 1'b0);
        chk("reset tick", bus.tick, 1'b0);
        chk("reset pend", bus.pend, 1'b0);

        // Square N=4 straight out of reset
        rst = 1'b0; bus.en = 1'b1;
        run_seq("sq4", 8, 16'b11001100, 16'b10001000);

        // Load 6 at cnt=1, applies at the cnt=3 boundary
        run_seq("sq4b", 2, 16'b11, 16'b10);
        bus.load = 1'b1; bus.div_in = 8'd6;
        step(); bus.load = 1'b0;
        chk("ld6 pend cnt2", bus.pend, 1'b1);
        chk("ld6 clk cnt2", bus.clk_div, 1'b0);
        step();
        chk("ld6 pend cnt3", bus.pend, 1'b1);
        run_seq("sq6", 7, 16'b1110001, 16'b1000001);
        chk("sq6 pend clr", bus.pend, 1'b0);

        // en low -> idle outputs
        bus.en = 1'b0;
        step();
        chk("idle clk_div", bus.clk_div, 1'b0);
        chk("idle tick", bus.tick, 1'b0);

        // div_in=0 clamps to 2, loaded in IDLE
        bus.load = 1'b1; bus.div_in = 8'd0;
        step(); bus.load = 1'b0;
        chk("ld0 pend", bus.pend, 1'b1);
        step();
        chk("ld0 idle apply", bus.pend, 1'b0);
        bus.en = 1'b1;
        run_seq("n2a", 4, 16'b1010, 16'b1010);

        // Load on a boundary waits one extra period
        bus.load = 1'b1; bus.div_in = 8'd5;
        step(); bus.load = 1'b0;
        chk("ld5 pend", bus.pend, 1'b1);
        chk("ld5 clk still N2", bus.clk_div, 1'b1);
        step();
        chk("ld5 pend cnt1", bus.pend, 1'b1);
        chk("ld5 clk cnt1", bus.clk_div, 1'b0);
        run_seq("sq5", 10, 16'b1110011100, 16'b1000010000);
        chk("sq5 pend clr", bus.pend, 1'b0);

        // div_in=1 clamps to 2
        bus.load = 1'b1; bus.div_in = 8'd1;
        step(); bus.load = 1'b0;
        chk("ld1 pend", bus.pend, 1'b1);
        run_seq("sq5 tail", 4, 16'b1100, 16'b0000);
        run_seq("n2b", 4, 16'b1010, 16'b1010);
        chk("ld1 pend clr", bus.pend, 1'b0);

        // Pulse mode, N=3 pending
        bus.load = 1'b1; bus.div_in = 8'd3; bus.mode = 1'b1;
        step(); bus.load = 1'b0;
        chk("pl first clk", bus.clk_div, 1'b1);
        chk("pl first tick", bus.tick, 1'b1);
        run_seq("pl3", 7, 16'b0100100, 16'b0100100);

        // Mode change mid-period only applies at the boundary
        run_seq("pl3b", 1, 16'b1, 16'b1);
        bus.mode = 1'b0;
        run_seq("mode sw", 5, 16'b00110, 16'b00100);

        // Reset at cnt=2 with a pending ratio
        bus.load = 1'b1; bus.div_in = 8'd7;
        step(); bus.load = 1'b0;
        run_seq("sq3 pre", 2, 16'b10, 16'b00);
        chk("pre-rst pend", bus.pend, 1'b1);
        rst = 1'b1;
        step();
        chk("rst clk_div", bus.clk_div, 1'b0);
        chk("rst tick", bus.tick, 1'b0);
        chk("rst pend", bus.pend, 1'b0);
        rst = 1'b0;
        run_seq("post rst", 8, 16'b11001100, 16'b10001000);
        chk("post rst pend", bus.pend, 1'b0);

        // rst beats en and load in the same cycle
        rst = 1'b1; bus.load = 1'b1; bus.div_in = 8'd9;
        step();
        rst = 1'b0; bus.load = 1'b0;
        chk("prio pend", bus.pend, 1'b0);
        chk("prio tick", bus.tick, 1'b0);
        run_seq("prio run", 4, 16'b1100, 16'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter DIV_W, default 8: width of the divide-ratio input and the internal counter.
REQ-002 Parameter DEF_DIV, default 4: divide ratio loaded at reset.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: run enable; 0 forces idle.
REQ-006 Port load, input, 1: one-cycle request to capture div_in.
REQ-007 Port div_in, input, DIV_W: requested divide ratio N.
REQ-008 Port mode, input, 1: output shape; 0 = square, 1 = pulse.
REQ-009 Port clk_div, output, 1: registered divided clock.
REQ-010 Port tick, output, 1: registered one-cycle strobe at the start of each period.
REQ-011 Port pend, output, 1: a loaded ratio is waiting to take effect.

Function
REQ-012 The block SHALL hold state IDLE or RUN. IDLE -> RUN on en=1. RUN -> IDLE on en=0. Each transition SHALL take effect at the next clock edge.
REQ-013 Registers SHALL be: cur_div (active N), pend_div, pend, and cnt (DIV_W bits).
REQ-014 Effective N SHALL be the ratio with values 0 and 1 clamped to 2.
REQ-015 On load=1, pend_div SHALL take div_in (clamped) and pend SHALL be set at the next edge.
REQ-016 A load while pend=1 SHALL overwrite pend_div; only the last value takes effect.
REQ-017 A pending ratio SHALL move to cur_div, clearing pend, only at a period boundary or in IDLE. A period boundary is RUN with cnt == cur_div-1.
REQ-018 A load in the same cycle as a boundary SHALL be captured, but SHALL NOT apply until the following boundary.
REQ-019 In RUN, cnt SHALL count 0 .. cur_div-1 and then wrap to 0. Counter arithmetic is unsigned DIV_W-bit and SHALL never overflow past cur_div-1.
REQ-020 On the IDLE -> RUN edge, cnt SHALL be 0.
REQ-021 Outputs are registered and aligned with cnt. In any RUN cycle, tick SHALL be 1 iff cnt == 0.
REQ-022 Square mode: clk_div SHALL be 1 iff cnt < ceil(N/2). Odd N therefore gives one extra high cycle; the period is always exactly N cycles.
REQ-023 Pulse mode: clk_div SHALL equal tick.
REQ-024 A change of mode mid-period SHALL be sampled only at a boundary, so no partial-period glitch occurs.
REQ-025 In IDLE, clk_div and tick SHALL be 0 and cnt SHALL be 0.
REQ-026 When en falls, clk_div and tick SHALL be 0 from the next edge.

Reset
REQ-027 When rst=1 at an edge: state IDLE, cnt=0, cur_div=DEF_DIV, pend_div=DEF_DIV, pend=0, clk_div=0, tick=0.
REQ-028 rst SHALL take priority over en and load in the same cycle.
REQ-029 Reset mid-period SHALL discard any pending ratio.
REQ-030 After reset release with en=1, the first RUN cycle SHALL have cnt=0, tick=1.

Structure
REQ-031 Shared package clk_div_pkg SHALL hold:
- state enum {IDLE, RUN}
- mode enum {SQUARE, PULSE}
- the clamp function
- default DIV_W and DEF_DIV constants.
REQ-032 The modulo counter with boundary flag SHALL be one sub-module, clk_div_cnt. The top holds the FSM, the ratio registers and the output decode.

Verification
REQ-033 Square N=4, en held high: clk_div 1,1,0,0 repeating; tick on every 4th cycle.
REQ-034 Square N=5: clk_div 1,1,1,0,0 repeating, period 5.
REQ-035 Pulse N=3: clk_div = tick = 1,0,0 repeating.
REQ-036 N=4 running, load div_in=6 at cnt=1:
- pend=1 until the boundary at cnt=3
- next period runs 6 cycles (3 high, 3 low).
REQ-037 load div_in=0 and, separately, div_in=1: both produce N=2 (clk_div 1,0 alternating).
REQ-038 rst=1 at cnt=2 with pend=1:
- next cycle: all outputs 0, pend=0
- after release: period 4 (DEF_DIV) starting with tick=1.
